register_file_arbiter: RTL and testbench

REGISTER_FILE_ARBITER -- requirements
Module: register_file_arbiter

---
 rtl/register_file_arbiter_if.sv | 26 ++
 rtl/register_file_arbiter.sv | 128 ++++++++++++
 tb/tb_register_file_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/register_file_arbiter_if.sv
// Requester-side write ports and register-file write port of register_file_arbiter.
// The master modport is the requester/register-file side; slave is the arbiter.
interface register_file_arbiter_if;
    logic        req0;
    logic        req1;
    logic [4:0]  wsel0;
    logic [4:0]  wsel1;
    logic [31:0] wdat0;
    logic [31:0] wdat1;
    logic        ack0;
    logic        ack1;
    logic        rf_WEN;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic        busy;

    modport master (
        output req0, req1, wsel0, wsel1, wdat0, wdat1,
        input  ack0, ack1, rf_WEN, rf_wsel, rf_wdat, busy
    );

    modport slave (
        input  req0, req1, wsel0, wsel1, wdat0, wdat1,
        output ack0, ack1, rf_WEN, rf_wsel, rf_wdat, busy
    );
endinterface

// File: rtl/register_file_arbiter.sv
// Round-robin two-requester write arbiter for a register file, one write per two cycles.
// Define RF_ARB_CLEAR_EN to zero registers 1..NREG-1 after reset before accepting requests.
module register_file_arbiter #(
    parameter int NREG = 32
) (
    input logic                   CLK,
    input logic                   nRST,
    register_file_arbiter_if.slave bus
);

    if (NREG < 2 || NREG > 32) begin : g_nreg_range
        $error("register_file_arbiter: NREG must be in 2..32");
    end

`ifdef RF_ARB_CLEAR_EN
    typedef enum logic [1:0] {CLEAR, IDLE, ISSUE} state_t;
    localparam state_t RST_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE, ISSUE} state_t;
    localparam state_t RST_STATE = IDLE;
`endif

    state_t      state, state_nx;
    logic        wen_q, wen_nx;
    logic        ack0_q, ack0_nx;
    logic        ack1_q, ack1_nx;
    logic [4:0]  wsel_q, wsel_nx;
    logic [31:0] wdat_q, wdat_nx;
    logic        last_q, last_nx;
    logic        grant1;

`ifdef RF_ARB_CLEAR_EN
    // One bit wider than a register index so the sweep end (NREG) is representable.
    logic [5:0]  clr_idx, clr_nx;
    logic        busy_q, busy_nx;
`endif

    // last_q holds the requester granted most recently; the other one wins a tie.
    assign grant1 = bus.req1 && (!bus.req0 || !last_q);

    always_comb begin
        state_nx = state;
        wen_nx   = 1'b0;
        ack0_nx  = 1'b0;
        ack1_nx  = 1'b0;
        wsel_nx  = wsel_q;
        wdat_nx  = wdat_q;
        last_nx  = last_q;
`ifdef RF_ARB_CLEAR_EN
        clr_nx   = clr_idx;
        busy_nx  = busy_q;
`endif
        case (state)
`ifdef RF_ARB_CLEAR_EN
            CLEAR: begin
                if (clr_idx == 6'(NREG)) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else begin
                    wen_nx  = 1'b1;
                    wsel_nx = clr_idx[4:0];
                    wdat_nx = '0;
                    clr_nx  = clr_idx + 6'd1;
                end
            end
`endif
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    state_nx = ISSUE;
                    last_nx  = grant1;
                    if (grant1) begin
                        wsel_nx = bus.wsel1;
                        wdat_nx = bus.wdat1;
                        ack1_nx = 1'b1;
                        wen_nx  = |bus.wsel1;
                    end else begin
                        wsel_nx = bus.wsel0;
                        wdat_nx = bus.wdat0;
                        ack0_nx = 1'b1;
                        wen_nx  = |bus.wsel0;
                    end
                end
            end
            ISSUE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state   <= RST_STATE;
            wen_q   <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            wsel_q  <= '0;
            wdat_q  <= '0;
            last_q  <= 1'b1;
`ifdef RF_ARB_CLEAR_EN
            clr_idx <= 6'd1;
            busy_q  <= 1'b1;
`endif
        end else begin
            state   <= state_nx;
            wen_q   <= wen_nx;
            ack0_q  <= ack0_nx;
            ack1_q  <= ack1_nx;
            wsel_q  <= wsel_nx;
            wdat_q  <= wdat_nx;
            last_q  <= last_nx;
`ifdef RF_ARB_CLEAR_EN
            clr_idx <= clr_nx;
            busy_q  <= busy_nx;
`endif
        end
    end

    assign bus.rf_WEN  = wen_q;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.rf_wsel = wsel_q;
    assign bus.rf_wdat = wdat_q;
`ifdef RF_ARB_CLEAR_EN
    assign bus.busy    = busy_q;
`else
    assign bus.busy    = 1'b0;
`endif

endmodule

// File: tb/tb_register_file_arbiter.sv
// Scoreboard bench for register_file_arbiter: stimulus queues expected acks, a negedge monitor retires them.
module tb_register_file_arbiter;
    localparam int NREG = 32;
`ifdef RF_ARB_CLEAR_EN
    localparam int   SWEEP    = NREG;
    localparam logic BUSY_RST = 1'b1;
`else
    localparam int   SWEEP    = 0;
    localparam logic BUSY_RST = 1'b0;
`endif

    typedef struct packed {
        logic        id;
        logic        wen;
        logic [4:0]  wsel;
        logic [31:0] wdat;
        logic [31:0] cyc;
    } exp_t;

    logic        CLK  = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] cyc  = '0;
    int          errors = 0;
    int          checks = 0;
    exp_t        q[$];
    logic        prev_wen = 1'b0;

    register_file_arbiter_if bus();

    register_file_arbiter #(.NREG(NREG)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 32'd1;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input logic r0, input logic r1, input logic [4:0] s0, input logic [4:0] s1,
                           input logic [31:0] d0, input logic [31:0] d1);
        bus.req0  = r0;
        bus.req1  = r1;
        bus.wsel0 = s0;
        bus.wsel1 = s1;
        bus.wdat0 = d0;
        bus.wdat1 = d1;
    endtask

    // Register 0 is hardwired, so a grant to it acknowledges without a write.
    task automatic expect_ack(input logic id, input logic [4:0] ws, input logic [31:0] wd, input logic [31:0] at);
        exp_t e;
        e.id   = id;
        e.wen  = (ws != 5'd0);
        e.wsel = ws;
        e.wdat = wd;
        e.cyc  = at;
        q.push_back(e);
    endtask

    task automatic sweep();
`ifdef RF_ARB_CLEAR_EN
        for (int k = 1; k < NREG; k++) begin
            step();
            check("sweep_wen",  32'(bus.rf_WEN), 32'd1);
            check("sweep_wsel", 32'(bus.rf_wsel), 32'(k));
            check("sweep_wdat", bus.rf_wdat, 32'd0);
            check("sweep_busy", 32'(bus.busy), 32'd1);
        end
        step();
        check("sweep_done_busy", 32'(bus.busy), 32'd0);
        check("sweep_done_wen",  32'(bus.rf_WEN), 32'd0);
`endif
    endtask

    always @(negedge CLK) begin
        exp_t e;
        exp_t a;
        if (nRST) begin
            checks++;
            if (bus.ack0 && bus.ack1) begin
                errors++;
                $display("FAIL ack_overlap: ack0=%b ack1=%b required not both (cycle %0d)", bus.ack0, bus.ack1, cyc);
            end else if (bus.rf_WEN && prev_wen && !bus.busy) begin
                errors++;
                $display("FAIL wen_back_to_back: rf_WEN high two cycles, required at most one (cycle %0d)", cyc);
            end else if (bus.rf_WEN && !bus.busy && !(bus.ack0 || bus.ack1)) begin
                errors++;
                $display("FAIL wen_without_ack: rf_WEN=1 with no ack, required 0 (cycle %0d)", cyc);
            end
            if (bus.ack0 || bus.ack1) begin
                checks++;
                a.id   = bus.ack1;
                a.wen  = bus.rf_WEN;
                a.wsel = bus.rf_wsel;
                a.wdat = bus.rf_wdat;
                a.cyc  = cyc;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: got id=%0d wsel=%0d wdat=%h at cycle %0d, required none",
                             a.id, a.wsel, a.wdat, a.cyc);
                end else begin
                    e = q.pop_front();
                    if (a !== e) begin
                        errors++;
                        $display("FAIL ack_txn: got id=%0d wen=%b wsel=%0d wdat=%h cyc=%0d, expected id=%0d wen=%b wsel=%0d wdat=%h cyc=%0d",
                                 a.id, a.wen, a.wsel, a.wdat, a.cyc, e.id, e.wen, e.wsel, e.wdat, e.cyc);
                    end
                end
            end
        end
        prev_wen = bus.rf_WEN;
    end

    initial begin
        logic [31:0] base;
        set_req(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        nRST = 1'b0;
        step();
        step();
        check("rst_wen",  32'(bus.rf_WEN), 32'd0);
        check("rst_ack0", 32'(bus.ack0), 32'd0);
        check("rst_ack1", 32'(bus.ack1), 32'd0);
        check("rst_wsel", 32'(bus.rf_wsel), 32'd0);
        check("rst_wdat", bus.rf_wdat, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'(BUSY_RST));

        // Both requesters held from reset release: grants alternate starting with 0.
        set_req(1'b1, 1'b1, 5'd3, 5'd4, 32'h3333_0000, 32'h4444_0000);
        nRST = 1'b1;
        base = cyc + 32'd1 + 32'(SWEEP);
        expect_ack(1'b0, 5'd3, 32'h3333_0000, base);
        expect_ack(1'b1, 5'd4, 32'h4444_0000, base + 32'd2);
        expect_ack(1'b0, 5'd3, 32'h3333_0000, base + 32'd4);
        expect_ack(1'b1, 5'd4, 32'h4444_0000, base + 32'd6);
        sweep();
        for (int g = 0; g < 100 && cyc < base + 32'd6; g++) step();
        set_req(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        step();

        // Single write from requester 0.
        set_req(1'b1, 1'b0, 5'd5, 5'd0, 32'hDEAD_BEEF, 32'h0);
        expect_ack(1'b0, 5'd5, 32'hDEAD_BEEF, cyc + 32'd1);
        step();
        set_req(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        step();

        // Write to register 0: acked without rf_WEN.
        set_req(1'b0, 1'b1, 5'd0, 5'd0, 32'h0, 32'h1);
        expect_ack(1'b1, 5'd0, 32'h1, cyc + 32'd1);
        step();
        set_req(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        step();

        // Tie after requester 1 won last: 0 wins, 1 withdraws before its grant and is never acked.
        set_req(1'b1, 1'b1, 5'd2, 5'd6, 32'h22, 32'h66);
        expect_ack(1'b0, 5'd2, 32'h22, cyc + 32'd1);
        step();
        set_req(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        step();
        step();

        // Reset hits the ISSUE cycle of a write to register 7: it is dropped.
        set_req(1'b0, 1'b1, 5'd0, 5'd7, 32'h0, 32'h77);
        step();
        nRST = 1'b0;
        #1;
        check("midissue_wen",  32'(bus.rf_WEN), 32'd0);
        check("midissue_ack1", 32'(bus.ack1), 32'd0);
        check("midissue_wsel", 32'(bus.rf_wsel), 32'd0);
        check("midissue_wdat", bus.rf_wdat, 32'd0);
        set_req(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        nRST = 1'b1;
        sweep();

        // Pointer back at its reset value: 0 wins the first tie; boundary register 31.
        set_req(1'b1, 1'b1, 5'd31, 5'd1, 32'hFFFF_FFFF, 32'hA5A5_A5A5);
        expect_ack(1'b0, 5'd31, 32'hFFFF_FFFF, cyc + 32'd1);
        expect_ack(1'b1, 5'd1, 32'hA5A5_A5A5, cyc + 32'd3);
        step();
        step();
        step();
        set_req(1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 32'h0);
        step();
        step();
        step();

        check("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
